// File: rtl/sia_frame_parser_if.sv
// Byte-stream, work and nonce signals between siaminer host side and the framer.
// master = host/bench side, slave = sia_frame_parser.
interface sia_frame_parser_if #(
   parameter int WORK_BYTES = 80,
   parameter int TGT_BYTES  = 4
);
   logic [7:0]              rx_data;
   logic                    new_rx_data;
   logic [7:0]              tx_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [WORK_BYTES*8-1:0] work;
   logic [TGT_BYTES*8-1:0]  target;
   logic                    work_valid;
   logic                    nonce_found;
   logic [31:0]             nonce;
   logic                    rx_last_byte;
   logic                    tx_last_byte;
   logic                    frame_err;

   modport slave (
      input  rx_data, new_rx_data, tx_ready, nonce_found, nonce,
      output tx_data, tx_valid, work, target, work_valid,
             rx_last_byte, tx_last_byte, frame_err
   );

   modport master (
      output rx_data, new_rx_data, tx_ready, nonce_found, nonce,
      input  tx_data, tx_valid, work, target, work_valid,
             rx_last_byte, tx_last_byte, frame_err
   );
endinterface

// File: rtl/sia_frame_parser.sv
// Host frame decoder (AA cmd len payload) and device frame encoder (55 cmd len payload).
// Optional RX inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module sia_frame_parser #(
   parameter int WORK_BYTES     = 80,
   parameter int TGT_BYTES      = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic               clk,
   input logic               rst_n,
   sia_frame_parser_if.slave bus
);

   localparam int PB = WORK_BYTES + TGT_BYTES;
   localparam int SW = PB * 8;
   localparam int WW = WORK_BYTES * 8;
   localparam int TW = TGT_BYTES * 8;
   localparam logic [7:0] WORK_LEN = 8'(PB);
   localparam logic [7:0] CMD_WORK = 8'h00;
   localparam logic [7:0] CMD_LOOP = 8'h01;

   typedef enum logic [1:0] {
      R_IDLE, R_CMD, R_LEN, R_DATA
   } rx_state_e;

   typedef enum logic [2:0] {
      T_IDLE, T_HDR, T_CMD, T_LEN, T_DATA
   } tx_state_e;

   rx_state_e     rx_state_q, rx_state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [SW-1:0] stage_q, stage_d;
   logic [SW-1:0] shifted;
   logic [WW-1:0] work_q, work_d;
   logic [TW-1:0] target_q, target_d;
   logic          work_valid_q, work_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    loop_byte_q, loop_byte_d;
   logic          loop_set;
   logic          rx_last;
   logic          rx_tmo;

   tx_state_e     tx_state_q, tx_state_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic [31:0]   pay_q, pay_d;
   logic [7:0]    tx_len_q, tx_len_d;
   logic          kind_q, kind_d;
   logic [7:0]    tcnt_q, tcnt_d;
   logic          nonce_pend_q, nonce_pend_d;
   logic [31:0]   nonce_val_q, nonce_val_d;
   logic          loop_pend_q, loop_pend_d;
   logic          accept;

   // New byte enters at the top so payload byte k ends up at bits [8k+7:8k].
   assign shifted = {bus.rx_data, stage_q[SW-1:8]};
   assign accept  = tx_valid_q & bus.tx_ready;

`ifdef RX_TIMEOUT_EN
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   logic [GW-1:0] gap_q, gap_d;

   // Gap counter: counts idle cycles inside a frame, cleared by every byte.
   always_comb begin
      gap_d = gap_q + 1'b1;
      if (bus.new_rx_data || rx_state_q == R_IDLE) gap_d = '0;
   end

   // Gap counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gap_q <= '0;
      else        gap_q <= gap_d;
   end

   assign rx_tmo = (rx_state_q != R_IDLE) && !bus.new_rx_data &&
                   (gap_q == GW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_tmo;
   assign unused_tmo = (TIMEOUT_CYCLES == 0);
   assign rx_tmo     = 1'b0;
`endif

   // RX next-state: frame decode, staging, commit of work/target and loop byte.
   always_comb begin
      rx_state_d   = rx_state_q;
      cmd_d        = cmd_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      stage_d      = stage_q;
      work_d       = work_q;
      target_d     = target_q;
      work_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      loop_byte_d  = loop_byte_q;
      loop_set     = 1'b0;
      rx_last      = 1'b0;
      if (bus.new_rx_data) begin
         unique case (rx_state_q)
            R_IDLE: begin
               if (bus.rx_data == 8'hAA) rx_state_d = R_CMD;
            end
            R_CMD: begin
               cmd_d      = bus.rx_data;
               rx_state_d = R_LEN;
            end
            R_LEN: begin
               len_d = bus.rx_data;
               cnt_d = '0;
               if (bus.rx_data == 8'h00) begin
                  rx_last     = 1'b1;
                  rx_state_d  = R_IDLE;
                  frame_err_d = (cmd_q != CMD_LOOP);
               end else begin
                  rx_state_d = R_DATA;
               end
            end
            R_DATA: begin
               stage_d = shifted;
               cnt_d   = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1) begin
                  rx_last    = 1'b1;
                  rx_state_d = R_IDLE;
                  if (cmd_q == CMD_WORK && len_q == WORK_LEN) begin
                     work_d       = shifted[WW-1:0];
                     target_d     = shifted[SW-1:WW];
                     work_valid_d = 1'b1;
                  end else if (cmd_q == CMD_LOOP) begin
                     loop_byte_d = bus.rx_data;
                     loop_set    = 1'b1;
                  end else begin
                     frame_err_d = 1'b1;
                  end
               end
            end
         endcase
      end
      if (rx_tmo) begin
         rx_state_d  = R_IDLE;
         stage_d     = '0;
         frame_err_d = 1'b1;
      end
   end

   // RX state and data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q   <= R_IDLE;
         cmd_q        <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         stage_q      <= '0;
         work_q       <= '0;
         target_q     <= '0;
         work_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         loop_byte_q  <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         cmd_q        <= cmd_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         stage_q      <= stage_d;
         work_q       <= work_d;
         target_q     <= target_d;
         work_valid_q <= work_valid_d;
         frame_err_q  <= frame_err_d;
         loop_byte_q  <= loop_byte_d;
      end
   end

   // TX next-state: arbitration, payload snapshot and byte sequencing.
   always_comb begin
      tx_state_d   = tx_state_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      pay_d        = pay_q;
      tx_len_d     = tx_len_q;
      kind_d       = kind_q;
      tcnt_d       = tcnt_q;
      nonce_pend_d = nonce_pend_q;
      nonce_val_d  = nonce_val_q;
      loop_pend_d  = loop_pend_q;
      case (tx_state_q)
         T_IDLE: begin
            if (nonce_pend_q || loop_pend_q) begin
               tx_state_d = T_HDR;
               tx_valid_d = 1'b1;
               tx_data_d  = 8'h55;
               if (nonce_pend_q) begin
                  kind_d       = 1'b0;
                  pay_d        = nonce_val_q;
                  tx_len_d     = 8'd4;
                  nonce_pend_d = 1'b0;
               end else begin
                  kind_d      = 1'b1;
                  pay_d       = {24'h0, loop_byte_q};
                  tx_len_d    = 8'd1;
                  loop_pend_d = 1'b0;
               end
            end
         end
         T_HDR: begin
            if (accept) begin
               tx_state_d = T_CMD;
               tx_data_d  = {7'h0, kind_q};
            end
         end
         T_CMD: begin
            if (accept) begin
               tx_state_d = T_LEN;
               tx_data_d  = tx_len_q;
            end
         end
         T_LEN: begin
            if (accept) begin
               tx_state_d = T_DATA;
               tx_data_d  = pay_q[7:0];
               pay_d      = pay_q >> 8;
               tcnt_d     = '0;
            end
         end
         T_DATA: begin
            if (accept) begin
               if (tcnt_q == tx_len_q - 8'd1) begin
                  tx_state_d = T_IDLE;
                  tx_valid_d = 1'b0;
               end else begin
                  tx_data_d = pay_q[7:0];
                  pay_d     = pay_q >> 8;
                  tcnt_d    = tcnt_q + 8'd1;
               end
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
      // A fresh nonce or loop byte wins over the clear from a frame start.
      if (bus.nonce_found) begin
         nonce_pend_d = 1'b1;
         nonce_val_d  = bus.nonce;
      end
      if (loop_set) loop_pend_d = 1'b1;
   end

   // TX state, output and pending registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q   <= T_IDLE;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         pay_q        <= '0;
         tx_len_q     <= '0;
         kind_q       <= 1'b0;
         tcnt_q       <= '0;
         nonce_pend_q <= 1'b0;
         nonce_val_q  <= '0;
         loop_pend_q  <= 1'b0;
      end else begin
         tx_state_q   <= tx_state_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         pay_q        <= pay_d;
         tx_len_q     <= tx_len_d;
         kind_q       <= kind_d;
         tcnt_q       <= tcnt_d;
         nonce_pend_q <= nonce_pend_d;
         nonce_val_q  <= nonce_val_d;
         loop_pend_q  <= loop_pend_d;
      end
   end

   assign bus.work         = work_q;
   assign bus.target       = target_q;
   assign bus.work_valid   = work_valid_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.rx_last_byte = rx_last;
   assign bus.tx_data      = tx_data_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.tx_last_byte = tx_valid_q && (tx_state_q == T_DATA) &&
                             (tcnt_q == tx_len_q - 8'd1);

endmodule

// File: tb/tb_sia_frame_parser.sv
// Randomised bench for sia_frame_parser with a byte-level frame model.
// Define RX_TIMEOUT_EN to exercise the inter-byte timeout (TIMEOUT_CYCLES=100).
module tb_sia_frame_parser;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

`ifdef RX_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 1000000;
`endif

   sia_frame_parser_if bus ();

   sia_frame_parser #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0]  txq[$];
   logic [15:0] tx_last_mask;
   int          wv_cnt = 0;
   int          fe_cnt = 0;
   int          rdy_mode = 0;
   logic        stall_q = 1'b0;
   logic [7:0]  stall_data;

   logic [7:0]  m_bytes[84];
   logic [7:0]  pl[256];

   // tx_ready driver: 0 high, 1 toggling, 2 low, 3 random
   initial begin
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            2:       bus.tx_ready = 1'b0;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: transfers, pulse counts, data stability under stall
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            n_total++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== stall_data)
               $display("FAIL tx_stable: valid=%b data=%h required valid=1 data=%h",
                        bus.tx_valid, bus.tx_data, stall_data);
            else
               n_pass++;
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (txq.size() < 16) tx_last_mask[txq.size()] = bus.tx_last_byte;
            txq.push_back(bus.tx_data);
         end
         stall_q    = bus.tx_valid && !bus.tx_ready;
         stall_data = bus.tx_data;
         if (bus.work_valid) wv_cnt++;
         if (bus.frame_err)  fe_cnt++;
      end
   end

   function automatic logic [127:0] pack_tx();
      logic [127:0] r = '0;
      for (int i = 0; i < txq.size() && i < 16; i++) r[8*i +: 8] = txq[i];
      return r;
   endfunction

   function automatic logic [639:0] exp_work();
      logic [639:0] r;
      for (int k = 0; k < 80; k++) r[8*k +: 8] = m_bytes[k];
      return r;
   endfunction

   function automatic logic [31:0] exp_target();
      return {m_bytes[83], m_bytes[82], m_bytes[81], m_bytes[80]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_tx();
      txq.delete();
      tx_last_mask = '0;
   endtask

   task automatic wait_tx(input int n, input int budget);
      int c = 0;
      while (txq.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      tick(3);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic last);
      bus.rx_data     = b;
      bus.new_rx_data = 1'b1;
      #1;
      last = bus.rx_last_byte;
      @(posedge clk);
      #1;
      bus.new_rx_data = 1'b0;
      bus.nonce_found = 1'b0;
   endtask

   // Sends AA cmd len pl[0..len-1]; optional nonce_found on the final byte.
   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                             input int gapmax, input logic nf,
                             input logic [31:0] nv, input string nm);
      logic l;
      int   nlast = 0;
      int   lpos  = -1;
      int   total = 3 + int'(len);
      for (int i = 0; i < total; i++) begin
         logic [7:0] b;
         b = (i == 0) ? 8'hAA : (i == 1) ? cmd : (i == 2) ? len : pl[i-3];
         if (i == total - 1 && nf) begin
            bus.nonce_found = 1'b1;
            bus.nonce       = nv;
         end
         send_byte(b, l);
         if (l) begin
            nlast++;
            lpos = i;
         end
         if (i < total - 1 && gapmax > 0) begin
            int g = $urandom_range(0, gapmax);
            if (g > 0) tick(g);
         end
      end
      n_total++;
      if (nlast !== 1 || lpos !== total - 1)
         $display("FAIL %s rx_last: count=%0d pos=%0d required count=1 pos=%0d",
                  nm, nlast, lpos, total - 1);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      n_total++;
      if (bus.work !== '0 || bus.target !== '0)
         $display("FAIL reset_work: work/target nonzero target=%h required 0", bus.target);
      else n_pass++;
      n_total++;
      if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00)
         $display("FAIL reset_tx: valid=%b data=%h required 0/00", bus.tx_valid, bus.tx_data);
      else n_pass++;
      n_total++;
      if (bus.work_valid !== 1'b0 || bus.frame_err !== 1'b0)
         $display("FAIL reset_pulses: wv=%b fe=%b required 0/0", bus.work_valid, bus.frame_err);
      else n_pass++;
      foreach (m_bytes[k]) m_bytes[k] = 8'h00;
   endtask

   task automatic test_work(input logic rnd);
      logic l;
      int   wv0 = wv_cnt;
      rdy_mode = 0;
      clear_tx();
      repeat (3) send_byte(8'($urandom_range(0, 8'hA9)), l);
      for (int k = 0; k < 84; k++) begin
         pl[k] = rnd ? 8'($urandom) : 8'(k);
         m_bytes[k] = pl[k];
      end
      send_frame(8'h00, 8'd84, rnd ? 2 : 0, 1'b0, '0, "work");
      n_total++;
      if (bus.work_valid !== 1'b1)
         $display("FAIL work_valid_lat: got %b required 1", bus.work_valid);
      else n_pass++;
      n_total++;
      if (bus.work !== exp_work())
         $display("FAIL work_data: got %h required %h", bus.work, exp_work());
      else n_pass++;
      n_total++;
      if (bus.target !== exp_target())
         $display("FAIL work_target: got %h required %h", bus.target, exp_target());
      else n_pass++;
      if (!rnd) begin
         n_total++;
         if (bus.work[7:0] !== 8'h00 || bus.work[639:632] !== 8'h4F ||
             bus.target !== 32'h53525150)
            $display("FAIL work_fixed: w0=%h w79=%h tgt=%h required 00 4f 53525150",
                     bus.work[7:0], bus.work[639:632], bus.target);
         else n_pass++;
      end
      tick(4);
      n_total++;
      if (wv_cnt - wv0 !== 1 || txq.size() !== 0)
         $display("FAIL work_pulse: pulses=%0d tx=%0d required 1 and 0",
                  wv_cnt - wv0, txq.size());
      else n_pass++;
   endtask

   task automatic test_loop(input logic [7:0] len);
      logic [7:0] b;
      int wv0 = wv_cnt;
      rdy_mode = 0;
      clear_tx();
      for (int k = 0; k < int'(len); k++) pl[k] = 8'($urandom);
      b = pl[len-1];
      send_frame(8'h01, len, 1, 1'b0, '0, "loop");
      wait_tx(4, 40);
      n_total++;
      if (txq.size() !== 4 || pack_tx() !== 128'({b, 8'h01, 8'h01, 8'h55}))
         $display("FAIL loop_echo: n=%0d got %h required 4 bytes %h",
                  txq.size(), pack_tx(), {b, 8'h01, 8'h01, 8'h55});
      else n_pass++;
      n_total++;
      if (tx_last_mask !== 16'h0008 || wv_cnt !== wv0)
         $display("FAIL loop_last: mask=%h wv=%0d required 0008 %0d",
                  tx_last_mask, wv_cnt, wv0);
      else n_pass++;
   endtask

   task automatic test_nonce_priority();
      logic [7:0]   lb = 8'($urandom);
      logic [127:0] e;
      rdy_mode = 1;
      clear_tx();
      pl[0] = lb;
      send_frame(8'h01, 8'd1, 0, 1'b1, 32'h12345678, "prio");
      wait_tx(11, 200);
      e = 128'({lb, 8'h01, 8'h01, 8'h55,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h04, 8'h00, 8'h55});
      n_total++;
      if (txq.size() !== 11 || pack_tx() !== e)
         $display("FAIL nonce_prio: n=%0d got %h required 11 bytes %h",
                  txq.size(), pack_tx(), e);
      else n_pass++;
      n_total++;
      if (tx_last_mask !== 16'h0440)
         $display("FAIL nonce_last: mask=%h required 0440", tx_last_mask);
      else n_pass++;
   endtask

   task automatic test_nonce_overwrite();
      logic [31:0]  c = $urandom;
      logic [31:0]  a = $urandom;
      logic [31:0]  b = $urandom;
      logic [127:0] e;
      rdy_mode = 2;
      clear_tx();
      tick(1);
      bus.nonce_found = 1'b1; bus.nonce = c; tick(1);
      bus.nonce_found = 1'b0; tick(3);
      bus.nonce_found = 1'b1; bus.nonce = a; tick(1);
      bus.nonce_found = 1'b0; tick(2);
      bus.nonce_found = 1'b1; bus.nonce = b; tick(1);
      bus.nonce_found = 1'b0; tick(2);
      rdy_mode = 3;
      wait_tx(14, 300);
      e = 128'({b, 8'h04, 8'h00, 8'h55, c, 8'h04, 8'h00, 8'h55});
      n_total++;
      if (txq.size() !== 14 || pack_tx() !== e)
         $display("FAIL nonce_overwrite: n=%0d got %h required 14 bytes %h",
                  txq.size(), pack_tx(), e);
      else n_pass++;
   endtask

   task automatic test_errors();
      int fe0 = fe_cnt;
      int wv0 = wv_cnt;
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(8'h00, 8'd3, 1, 1'b0, '0, "err_len");
      n_total++;
      if (bus.frame_err !== 1'b1)
         $display("FAIL err_len_pulse: got %b required 1", bus.frame_err);
      else n_pass++;
      pl[0] = 8'h44; pl[1] = 8'h55;
      send_frame(8'h07, 8'd2, 1, 1'b0, '0, "err_cmd");
      n_total++;
      if (bus.frame_err !== 1'b1)
         $display("FAIL err_cmd_pulse: got %b required 1", bus.frame_err);
      else n_pass++;
      tick(3);
      n_total++;
      if (fe_cnt - fe0 !== 2 || wv_cnt !== wv0)
         $display("FAIL err_count: fe=%0d wv=%0d required 2 0", fe_cnt - fe0, wv_cnt - wv0);
      else n_pass++;
      n_total++;
      if (bus.work !== exp_work() || bus.target !== exp_target())
         $display("FAIL err_unchanged: target=%h required %h", bus.target, exp_target());
      else n_pass++;
      test_loop(8'd1);
   endtask

   task automatic test_reset_midframe();
      logic l;
      int   wv0;
      rdy_mode = 2;
      clear_tx();
      pl[0] = 8'hC3;
      send_frame(8'h01, 8'd1, 0, 1'b0, '0, "pend");
      send_byte(8'hAA, l); send_byte(8'h00, l); send_byte(8'd84, l);
      for (int k = 0; k < 40; k++) send_byte(8'($urandom), l);
      rst_n = 1'b0;
      #2;
      foreach (m_bytes[k]) m_bytes[k] = 8'h00;
      n_total++;
      if (bus.work !== '0 || bus.target !== '0 || bus.tx_valid !== 1'b0)
         $display("FAIL mid_reset: target=%h valid=%b required 0 0", bus.target, bus.tx_valid);
      else n_pass++;
      tick(2);
      rst_n = 1'b1;
      rdy_mode = 0;
      tick(1);
      clear_tx();
      wv0 = wv_cnt;
      for (int k = 0; k < 84; k++) begin
         pl[k] = 8'($urandom);
         m_bytes[k] = pl[k];
      end
      send_frame(8'h00, 8'd84, 1, 1'b0, '0, "resend");
      tick(10);
      n_total++;
      if (wv_cnt - wv0 !== 1 || bus.work !== exp_work() || bus.target !== exp_target())
         $display("FAIL resend: pulses=%0d target=%h required 1 %h",
                  wv_cnt - wv0, bus.target, exp_target());
      else n_pass++;
      n_total++;
      if (txq.size() !== 0)
         $display("FAIL reset_drops_pend: tx bytes=%0d required 0", txq.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0 = 8'($urandom);
      logic [7:0] b1 = 8'($urandom);
      rdy_mode = 0;
      clear_tx();
      pl[0] = b0;
      send_frame(8'h01, 8'd1, 0, 1'b0, '0, "b2b0");
      pl[0] = b1;
      send_frame(8'h01, 8'd1, 0, 1'b0, '0, "b2b1");
      wait_tx(8, 60);
      n_total++;
      if (txq.size() !== 8 ||
          pack_tx() !== 128'({b1, 8'h01, 8'h01, 8'h55, b0, 8'h01, 8'h01, 8'h55}))
         $display("FAIL back_to_back: n=%0d got %h required 8 bytes", txq.size(), pack_tx());
      else n_pass++;
   endtask

   task automatic test_gap();
      logic l;
      int   fe0 = fe_cnt;
      rdy_mode = 0;
      clear_tx();
`ifdef RX_TIMEOUT_EN
      send_byte(8'hAA, l); send_byte(8'h00, l);
      tick(101);
      n_total++;
      if (fe_cnt - fe0 !== 1)
         $display("FAIL timeout_err: pulses=%0d required 1", fe_cnt - fe0);
      else n_pass++;
      pl[0] = 8'h33;
      send_frame(8'h01, 8'd1, 0, 1'b0, '0, "tmo_loop");
      wait_tx(4, 40);
      n_total++;
      if (txq.size() !== 4 || pack_tx() !== 128'(32'h33010155))
         $display("FAIL timeout_echo: n=%0d got %h required 33010155", txq.size(), pack_tx());
      else n_pass++;
`else
      send_byte(8'hAA, l); send_byte(8'h01, l);
      tick(150);
      send_byte(8'h01, l); send_byte(8'h5A, l);
      wait_tx(4, 40);
      n_total++;
      if (txq.size() !== 4 || pack_tx() !== 128'(32'h5A010155) || fe_cnt !== fe0)
         $display("FAIL slow_frame: n=%0d got %h fe=%0d required 5a010155 0",
                  txq.size(), pack_tx(), fe_cnt - fe0);
      else n_pass++;
`endif
   endtask

   initial begin
      bus.rx_data     = 8'h00;
      bus.new_rx_data = 1'b0;
      bus.nonce_found = 1'b0;
      bus.nonce       = 32'h0;
      tx_last_mask    = '0;
      #2 rst_n = 1'b0;
      #1;
      test_reset();
      tick(2);
      rst_n = 1'b1;
      tick(2);
      test_work(1'b0);
      test_work(1'b1);
      test_loop(8'd1);
      test_loop(8'd3);
      test_nonce_priority();
      test_nonce_overwrite();
      test_errors();
      test_back_to_back();
      test_reset_midframe();
      test_gap();
      tick(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sia_frame_parser.md
Name: sia_frame_parser

Overview:
- Byte-level command framer between the UART byte engine and siacore inside siaminer.
- RX: decodes host frames (0xAA, cmd, len, payload) into a 640-bit work word plus 32-bit target, or into a loop-test byte.
- TX: serialises nonce results and loop echoes into device frames (0x55, cmd, len, payload) for the UART transmitter.

Parameters:
- WORK_BYTES, 80, work payload bytes (640 bits)
- TGT_BYTES, 4, target payload bytes; work command len = WORK_BYTES+TGT_BYTES = 84
- TIMEOUT_CYCLES, 1000000, inter-byte gap limit in clk cycles (used only with RX_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter can accept; transfer when tx_valid & tx_ready
- work  out  640  work block, byte k at bits [8k+7:8k]
- target  out  32  target, payload bytes 80..83, LSB first
- work_valid  out  1  one-cycle pulse: new work/target loaded
- nonce_found  in  1  one-cycle strobe from siacore
- nonce  in  32  nonce qualified by nonce_found
- rx_last_byte  out  1  high while the byte being accepted closes a frame
- tx_last_byte  out  1  high while tx_data is the final byte of a frame
- frame_err  out  1  one-cycle pulse on discarded frame

Behaviour:
- Reset (async, rst_n low): work=0, target=0, all pulses 0, tx_valid=0, tx_data=0, both FSMs in IDLE, pending flags cleared. Reset mid-frame drops the partial frame and any pending response.
- RX FSM: R_IDLE -> R_CMD -> R_LEN -> R_DATA -> R_IDLE. Advances only on new_rx_data.
  - R_IDLE: bytes other than 0xAA are ignored.
  - R_LEN with len=0: return to R_IDLE; rx_last_byte=1 on the len byte.
- Payload: byte counter 0..len-1, each byte shifted into a staging register; work/target are not touched during reception.
- cmd 0x00 and len==84:
  - On the last byte, staging is copied to work/target.
  - work_valid pulses the next cycle (latency 1 after the final new_rx_data).
- cmd 0x00 with len!=84: consume len bytes, discard, frame_err pulse, work/target unchanged.
- cmd 0x01: on the last byte, latch it as loop byte and set loop_pend. len>1 echoes only the final byte.
- Any other cmd: consume len bytes, discard, frame_err pulse.
- nonce_found: latch nonce and set nonce_pend.
  - If a nonce is already pending and not yet started, the new value overwrites it.
  - If nonce_found coincides with TX start of a nonce frame, the new nonce is kept pending for the next frame.
- TX FSM: T_IDLE -> T_HDR -> T_CMD -> T_LEN -> T_DATA -> T_IDLE. Each state advances on tx_valid & tx_ready.
- T_IDLE arbitration: nonce_pend has priority over loop_pend. The selected pend flag clears when T_HDR is entered; the payload is snapshotted at that point.
- Nonce frame bytes: 0x55, 0x00, 0x04, nonce[7:0], [15:8], [23:16], [31:24].
- Loop frame bytes: 0x55, 0x01, 0x01, loop byte.
- tx_valid is registered; bytes back-to-back with tx_ready held high. tx_data is stable while tx_valid & !tx_ready.
- RX and TX run concurrently; an incoming frame never stalls TX.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined: a gap counter runs in R_CMD/R_LEN/R_DATA and resets on each new_rx_data. On reaching TIMEOUT_CYCLES, the RX FSM returns to R_IDLE, the staging register is discarded and frame_err pulses.
- Undefined: no counter; the RX FSM waits indefinitely for the next byte.

Test Plan:
- Send AA 00 54, then 84 bytes 0x00..0x53 -> work_valid one cycle after the last byte; work[7:0]=0x00, work[639:632]=0x4F, target=0x53525150.
- Send AA 01 01 5A -> tx sequence 55 01 01 5A; no work_valid.
- nonce_found with nonce=0x12345678 while a loop echo is pending, tx_ready toggling 1/0 -> nonce frame 55 00 04 78 56 34 12 first, then the loop frame; tx_data stable while stalled.
- Send AA 00 03 11 22 33, then AA 07 02 44 55 -> two frame_err pulses; work/target unchanged; the parser then accepts a valid loop frame.
- Assert rst_n low after 40 payload bytes of a work frame, then resend the full frame -> the single work_valid carries only the second frame's data.
- With RX_TIMEOUT_EN and TIMEOUT_CYCLES=100: send AA 00, then idle 101 cycles -> frame_err, RX FSM in R_IDLE; a following AA 01 01 33 echoes 33.
